// File: rtl/traffic_cfg_pkg.sv
// Shared types for the traffic timing configuration front end: FSM states, edit_sel codes, default width.
// Pure declarations: no latency, no backpressure.
package traffic_cfg_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_EDIT_RED,
    ST_EDIT_YELLOW,
    ST_EDIT_GREEN,
    ST_COMMIT
  } cfg_state_e;

  localparam logic [1:0] SEL_NONE   = 2'b00;
  localparam logic [1:0] SEL_RED    = 2'b01;
  localparam logic [1:0] SEL_YELLOW = 2'b10;
  localparam logic [1:0] SEL_GREEN  = 2'b11;

  localparam int TIME_W_DEF = 8;

endpackage

// File: rtl/button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-flop sync, debounce, registered rise detect.
// Latency: pulse DEB_CYCLES+3 edges after first high sample; no backpressure (pulse is fire-and-forget).
module button_conditioner #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1, sync2;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // The edge that would bring the count to DEB_CYCLES flips the level instead.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/traffic_timing_config.sv
// Button-driven editor for red/yellow/green durations; shadows commit atomically (cfg_update pulse).
// Latency: outputs one cycle after COMMIT; no backpressure. Optional edit timeout: TTC_EDIT_TIMEOUT_EN.
module traffic_timing_config
  import traffic_cfg_pkg::*;
#(
  parameter int TIME_W     = TIME_W_DEF,
  parameter int DEB_CYCLES = 4,
  parameter int MIN_TIME   = 1,
  parameter int MAX_TIME   = 255,
  parameter int DEF_RED    = 5,
  parameter int DEF_YELLOW = 2,
  parameter int DEF_GREEN  = 3
`ifdef TTC_EDIT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_save,
  output logic              config_mode,
  output logic [TIME_W-1:0] red_time,
  output logic [TIME_W-1:0] yellow_time,
  output logic [TIME_W-1:0] green_time,
  output logic [1:0]        edit_sel,
  output logic [TIME_W-1:0] edit_value,
  output logic              cfg_update
);

  localparam logic [TIME_W-1:0] MIN_V = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_TIME);

  logic p_mode, p_up, p_down, p_save;

  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (.clk(clk), .rst_n(rst_n), .btn(btn_mode), .press(p_mode));
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_up   (.clk(clk), .rst_n(rst_n), .btn(btn_up),   .press(p_up));
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_down (.clk(clk), .rst_n(rst_n), .btn(btn_down), .press(p_down));
  button_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_save (.clk(clk), .rst_n(rst_n), .btn(btn_save), .press(p_save));

  function automatic logic [TIME_W-1:0] adjust(input logic [TIME_W-1:0] v,
                                               input logic inc, input logic dec);
    logic [TIME_W-1:0] r;
    r = v;
    if (inc && !dec && v < MAX_V)      r = v + 1'b1;
    else if (dec && !inc && v > MIN_V) r = v - 1'b1;
    return r;
  endfunction

  cfg_state_e        state, state_nx;
  logic [TIME_W-1:0] red_sh, yellow_sh, green_sh;
  logic [TIME_W-1:0] red_sh_nx, yellow_sh_nx, green_sh_nx;
  logic [1:0]        sel_nx;
  logic [TIME_W-1:0] value_nx;
  logic              editing;

  assign editing = (state == ST_EDIT_RED) || (state == ST_EDIT_YELLOW) || (state == ST_EDIT_GREEN);

`ifdef TTC_EDIT_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  logic          any_pulse, timeout;

  assign any_pulse = p_mode | p_up | p_down | p_save;
  assign timeout   = editing && !any_pulse && (idle_cnt == IW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 idle_cnt <= '0;
    else if (any_pulse || !editing) idle_cnt <= '0;
    else                        idle_cnt <= idle_cnt + 1'b1;
  end
`endif

  always_comb begin
    state_nx     = state;
    red_sh_nx    = red_sh;
    yellow_sh_nx = yellow_sh;
    green_sh_nx  = green_sh;
    case (state)
      ST_RUN: begin
        if (p_mode) begin
          state_nx     = ST_EDIT_RED;
          red_sh_nx    = red_time;
          yellow_sh_nx = yellow_time;
          green_sh_nx  = green_time;
        end
      end
      ST_EDIT_RED: begin
        red_sh_nx = adjust(red_sh, p_up, p_down);
        if (p_save)      state_nx = ST_COMMIT;
        else if (p_mode) state_nx = ST_EDIT_YELLOW;
      end
      ST_EDIT_YELLOW: begin
        yellow_sh_nx = adjust(yellow_sh, p_up, p_down);
        if (p_save)      state_nx = ST_COMMIT;
        else if (p_mode) state_nx = ST_EDIT_GREEN;
      end
      ST_EDIT_GREEN: begin
        green_sh_nx = adjust(green_sh, p_up, p_down);
        if (p_save)      state_nx = ST_COMMIT;
        else if (p_mode) state_nx = ST_EDIT_RED;
      end
      default: state_nx = ST_RUN;
    endcase
`ifdef TTC_EDIT_TIMEOUT_EN
    // Abandoned edit: drop the shadows back to the live values.
    if (timeout) begin
      state_nx     = ST_RUN;
      red_sh_nx    = red_time;
      yellow_sh_nx = yellow_time;
      green_sh_nx  = green_time;
    end
`endif
  end

  always_comb begin
    sel_nx   = SEL_NONE;
    value_nx = '0;
    case (state_nx)
      ST_EDIT_RED:    begin sel_nx = SEL_RED;    value_nx = red_sh_nx;    end
      ST_EDIT_YELLOW: begin sel_nx = SEL_YELLOW; value_nx = yellow_sh_nx; end
      ST_EDIT_GREEN:  begin sel_nx = SEL_GREEN;  value_nx = green_sh_nx;  end
      default:        begin sel_nx = SEL_NONE;   value_nx = '0;           end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      red_time    <= TIME_W'(DEF_RED);
      yellow_time <= TIME_W'(DEF_YELLOW);
      green_time  <= TIME_W'(DEF_GREEN);
      red_sh      <= TIME_W'(DEF_RED);
      yellow_sh   <= TIME_W'(DEF_YELLOW);
      green_sh    <= TIME_W'(DEF_GREEN);
      config_mode <= 1'b0;
      edit_sel    <= SEL_NONE;
      edit_value  <= '0;
      cfg_update  <= 1'b0;
    end else begin
      state     <= state_nx;
      red_sh    <= red_sh_nx;
      yellow_sh <= yellow_sh_nx;
      green_sh  <= green_sh_nx;
      if (state == ST_COMMIT) begin
        red_time    <= red_sh;
        yellow_time <= yellow_sh;
        green_time  <= green_sh;
      end
      config_mode <= (state_nx != ST_RUN);
      cfg_update  <= (state_nx == ST_COMMIT);
      edit_sel    <= sel_nx;
      edit_value  <= value_nx;
    end
  end

endmodule

// File: tb/tb_traffic_timing_config.sv
// Directed bench for traffic_timing_config; committed duration sets are checked through a scoreboard queue.
module tb_traffic_timing_config;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_save = 1'b0;
  logic       config_mode, cfg_update;
  logic [7:0] red_time, yellow_time, green_time, edit_value;
  logic [1:0] edit_sel;

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_SAVE = 4'b1000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] y;
    logic [7:0] g;
  } times_t;

  times_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  traffic_timing_config #(
`ifdef TTC_EDIT_TIMEOUT_EN
    .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_save(btn_save),
    .config_mode(config_mode), .red_time(red_time), .yellow_time(yellow_time),
    .green_time(green_time), .edit_sel(edit_sel), .edit_value(edit_value),
    .cfg_update(cfg_update)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] m);
    {btn_save, btn_down, btn_up, btn_mode} = m;
    repeat (10) @(negedge clk);
    {btn_save, btn_down, btn_up, btn_mode} = 4'b0000;
    repeat (10) @(negedge clk);
  endtask

  task automatic expect_commit(input logic [7:0] r, input logic [7:0] y, input logic [7:0] g);
    times_t t;
    t.r = r; t.y = y; t.g = g;
    sb.push_back(t);
    exp_pulses++;
  endtask

  // Every cfg_update must match a queued commit; the new set must appear the following cycle.
  always @(negedge clk) begin
    if (rst_n && cfg_update) begin
      times_t e;
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_cfg_update", {31'd0, cfg_update}, 32'd0);
      end else begin
        e = sb.pop_front();
        @(negedge clk);
        chk("cfg_update_width", {31'd0, cfg_update}, 32'd0);
        chk("commit_red", red_time, e.r);
        chk("commit_yellow", yellow_time, e.y);
        chk("commit_green", green_time, e.g);
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_red", red_time, 5);
    chk("rst_yellow", yellow_time, 2);
    chk("rst_green", green_time, 3);
    chk("rst_config_mode", config_mode, 0);
    chk("rst_edit_sel", edit_sel, 0);
    chk("rst_edit_value", edit_value, 0);
    chk("rst_cfg_update", cfg_update, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-cycle glitch must never produce a press
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("glitch_no_pulse", dut.u_btn_up.press, 0);
    end
    // Held button: one pulse, seen after the 7th edge
    btn_up = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold_pulse_edge%0d", i), dut.u_btn_up.press, (i == 7) ? 1 : 0);
    end
    btn_up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("release_no_pulse", dut.u_btn_up.press, 0);
    end
    chk("run_ignores_up", red_time, 5);
    chk("run_still_run", config_mode, 0);

    // Edit red 5 -> 10 and save
    press(B_MODE);
    chk("edit_config_mode", config_mode, 1);
    chk("edit_sel_red", edit_sel, 1);
    chk("edit_value_red0", edit_value, 5);
    for (int i = 1; i <= 5; i++) begin
      press(B_UP);
      chk($sformatf("red_up%0d", i), edit_value, 5 + i);
    end
    chk("red_not_live_yet", red_time, 5);
    expect_commit(10, 2, 3);
    press(B_SAVE);
    chk("after_save_mode", config_mode, 0);
    chk("after_save_sel", edit_sel, 0);
    chk("after_save_red", red_time, 10);
    chk("after_save_yellow", yellow_time, 2);
    chk("after_save_green", green_time, 3);

    // Saturation at MIN on yellow and MAX on green
    press(B_MODE);
    chk("reload_red_shadow", edit_value, 10);
    press(B_MODE);
    chk("edit_sel_yellow", edit_sel, 2);
    chk("edit_value_yellow", edit_value, 2);
    press(B_DOWN);
    chk("yellow_down1", edit_value, 1);
    press(B_DOWN);
    chk("yellow_down_sat2", edit_value, 1);
    press(B_DOWN);
    chk("yellow_down_sat3", edit_value, 1);
    press(B_MODE);
    chk("edit_sel_green", edit_sel, 3);
    chk("edit_value_green", edit_value, 3);
    for (int i = 0; i < 252; i++) press(B_UP);
    chk("green_reach_max", edit_value, 255);
    press(B_UP);
    chk("green_up_sat", edit_value, 255);
    press(B_UP | B_DOWN);
    chk("up_down_same_cycle", edit_value, 255);
    chk("green_not_live_yet", green_time, 3);

    // save+mode together commits rather than wrapping to red
    expect_commit(10, 1, 255);
    press(B_SAVE | B_MODE);
    chk("save_prio_mode", config_mode, 0);
    chk("save_prio_sel", edit_sel, 0);
    chk("save_prio_green", green_time, 255);

    // save/down in RUN do nothing
    press(B_SAVE);
    press(B_DOWN);
    chk("run_save_ignored", config_mode, 0);
    chk("run_down_ignored", yellow_time, 1);

    press(B_MODE);
    for (int i = 0; i < 3; i++) press(B_UP);
    chk("red_shadow_13", edit_value, 13);
`ifdef TTC_EDIT_TIMEOUT_EN
    repeat (30) @(negedge clk);
    chk("timeout_not_yet", config_mode, 1);
    repeat (20) @(negedge clk);
    chk("timeout_run", config_mode, 0);
    chk("timeout_sel", edit_sel, 0);
    chk("timeout_red_kept", red_time, 10);
    press(B_MODE);
    chk("timeout_shadow_dropped", edit_value, 10);
`else
    repeat (60) @(negedge clk);
    chk("no_timeout_mode", config_mode, 1);
    chk("no_timeout_value", edit_value, 13);
`endif

    // Asynchronous reset in the middle of an edit
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_red", red_time, 5);
    chk("arst_yellow", yellow_time, 2);
    chk("arst_green", green_time, 3);
    chk("arst_config_mode", config_mode, 0);
    chk("arst_edit_sel", edit_sel, 0);
    chk("arst_edit_value", edit_value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press(B_MODE);
    chk("post_rst_shadow", edit_value, 5);

    repeat (5) @(negedge clk);
    chk("cfg_update_count", pulses, exp_pulses);
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/traffic_timing_config.md
Name: traffic_timing_config

Overview:
Operator-facing configuration front end that sits directly upstream of traffic_light_controller. It turns four raw push-buttons into edited red/yellow/green phase durations and drives the controller's config_mode, red_time, yellow_time and green_time inputs. Edits are held in shadow registers and applied atomically on save, so the controller never sees a half-edited set.

Parameters:
TIME_W, 8, width of every duration value
DEB_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=2)
MIN_TIME, 1, lowest legal duration (>=1)
MAX_TIME, 255, highest legal duration (<= 2**TIME_W-1)
DEF_RED, 5, reset value of red_time
DEF_YELLOW, 2, reset value of yellow_time
DEF_GREEN, 3, reset value of green_time

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  raw button (async): step to next phase to edit / enter edit
btn_up  in  1  raw button (async): increment selected shadow value
btn_down  in  1  raw button (async): decrement selected shadow value
btn_save  in  1  raw button (async): commit shadows, return to run
config_mode  out  1  high while editing; feeds controller config_mode
red_time  out  TIME_W  active red duration
yellow_time  out  TIME_W  active yellow duration
green_time  out  TIME_W  active green duration
edit_sel  out  2  00 none, 01 red, 10 yellow, 11 green (display)
edit_value  out  TIME_W  shadow value of selected phase, 0 when edit_sel=00
cfg_update  out  1  one-cycle pulse when new durations are applied

Behaviour:
- Reset (async assert, sync-released internally by flops): state RUN; red/yellow/green_time = DEF_*; shadows = DEF_*; config_mode=0, edit_sel=00, edit_value=0, cfg_update=0; debounce counters and levels 0.
- Button conditioning, per button: 2-flop synchronizer, then debounce. The counter increments while the synced level differs from the debounced level and clears when the two agree. The debounced level toggles when the counter reaches DEB_CYCLES. The press pulse is a registered 1-cycle rise of the debounced level, high exactly DEB_CYCLES+3 clock edges after the first edge that samples the raw input high. Glitches shorter than DEB_CYCLES produce no pulse. A held button gives exactly one pulse.
- FSM states: RUN, EDIT_RED, EDIT_YELLOW, EDIT_GREEN, COMMIT.
- RUN + mode pulse -> EDIT_RED. Shadows are loaded from the active values on this transition.
- EDIT_RED -> EDIT_YELLOW -> EDIT_GREEN -> EDIT_RED on successive mode pulses.
- Any EDIT state + save pulse -> COMMIT. Save has priority over mode in the same cycle.
- COMMIT -> RUN unconditionally after 1 cycle. In COMMIT, active registers <= shadows, and cfg_update=1 during the COMMIT cycle. New values are visible on the outputs in the cycle after COMMIT.
- up/down act only in EDIT states, on the selected shadow. Arithmetic saturates: up at MAX_TIME stays at MAX_TIME, down at MIN_TIME stays at MIN_TIME; there is no wrap.
- up and down pulsing in the same cycle: no change.
- up/down/save pulses in RUN are ignored.
- config_mode = 1 in EDIT_* and COMMIT; 0 in RUN.
- edit_sel and edit_value are registered from the next state and shadow, so they are valid in the same cycle as the state.
- Active outputs change only in COMMIT or on reset.
- Reset mid-edit: shadows are discarded, outputs return to DEF_*.

Optional Feature:
Macro TTC_EDIT_TIMEOUT_EN.
- Defined: adds parameter TIMEOUT_CYCLES (default 1000). An idle counter clears on any button pulse and counts cycles while in EDIT_*. When it reaches TIMEOUT_CYCLES, the FSM goes to RUN, shadows are discarded (active values unchanged) and cfg_update stays 0.
- Undefined: EDIT states persist indefinitely, and no counter logic exists.

Decomposition:
- Package traffic_cfg_pkg holds:
  - cfg_state_e enum;
  - edit_sel encoding constants (SEL_NONE/RED/YELLOW/GREEN);
  - default TIME_W.
- Sub-module button_conditioner (synchronizer + debounce + rise pulse, DEB_CYCLES parameter), instantiated four times.
- FSM, shadows and saturating arithmetic live in the top.

Test Plan:
- Reset with rst_n low -> red/yellow/green_time=5/2/3, config_mode=0, edit_sel=00; assert rst_n low mid-cycle and check the outputs clear asynchronously.
- Raw btn_up glitch of 2 cycles, then a 10-cycle hold (DEB_CYCLES=4) -> no pulse for the glitch; exactly one internal pulse, at edge 7 after the hold starts.
- mode, then up x5, save -> config_mode rises; edit_sel=01; edit_value 5→10; cfg_update pulses once; red_time=10 one cycle after COMMIT; yellow and green unchanged.
- Saturation: select yellow (2), down x3 -> edit_value 1 (stays at MIN_TIME); set green shadow to 255 then up -> 255.
- Same-cycle save+mode in EDIT_GREEN -> COMMIT taken, not EDIT_RED; same-cycle up+down -> shadow unchanged.
- With TTC_EDIT_TIMEOUT_EN and TIMEOUT_CYCLES=50: enter edit, up x3, idle 50 cycles -> back to RUN, red_time still the prior value, cfg_update never asserted.
